minx_mem_ctrl: RTL
==================

Name: minx_mem_ctrl

Overview:
- Memory-side stage directly downstream of the minx top level. It consumes the minx bus outputs: address_out, data_out, read, write.
- It decodes each access to one of three targets: internal 4 KB BIOS ROM, internal 4 KB work RAM, or the external cartridge port.
- It returns the byte that feeds minx data_in.
- Cartridge accesses are variable-latency, so the block drives a stall that the top level uses to gate the minx clock enable.

Parameters:
- BIOS_DEPTH, 4096, BIOS bytes; power of two.
- RAM_DEPTH, 4096, work RAM bytes; power of two.
- CART_TIMEOUT, 64, cycles to wait for cart_ack before the access is abandoned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- bus_address  in  24  minx address_out.
- bus_data_in  in  8  minx data_out (write data).
- bus_read  in  1  minx read strobe.
- bus_write  in  1  minx write strobe.
- bus_data_out  out  8  read data returned to minx data_in.
- stall  out  1  high while a cartridge access is outstanding.
- bios_load_we  in  1  BIOS image load strobe, used before CPU release.
- bios_load_addr  in  12  BIOS load address.
- bios_load_data  in  8  BIOS load byte.
- cart_req  out  1  cartridge request; held until ack.
- cart_we  out  1  1 = write, 0 = read; valid while cart_req.
- cart_addr  out  21  cartridge byte address.
- cart_wdata  out  8  cartridge write data.
- cart_ack  in  1  one-cycle completion from the cartridge.
- cart_rdata  in  8  read data; valid with cart_ack.
- cart_timeout_err  out  1  sticky; set on any cartridge timeout.

Behaviour:
- Reset (async) values:
  - bus_data_out = 0x00, stall = 0, cart_req = 0, cart_we = 0, cart_addr = 0, cart_wdata = 0, cart_timeout_err = 0.
  - FSM = IDLE.
  - RAM contents are undefined. BIOS contents are retained; only bios_load_we writes them.
- Access start:
  - An access starts on a posedge where (bus_read | bus_write) = 1, the strobe was 0 on the previous cycle, and FSM = IDLE.
  - A strobe held high for several cycles is therefore one access.
  - If read and write are both high, the write wins.
- Decode on bus_address:
  - 0x000000-0x000FFF → BIOS (read-only; writes are ignored).
  - 0x001000-0x001FFF → RAM, index address[11:0].
  - 0x002000-0x0020FF → register space, handled inside minx. Reads return 0x00, writes are ignored, no stall.
  - 0x002100-0xFFFFFF → cartridge, with cart_addr = address[20:0]. Addresses above 0x1FFFFF mirror.
- BIOS and RAM timing:
  - Single-cycle. Read data is registered into bus_data_out at the start edge, so it is visible the next cycle.
  - A RAM write commits at the start edge.
  - stall never asserts for BIOS or RAM.
- Cartridge FSM, states IDLE → CART → IDLE:
  - On the start edge: cart_req = 1, stall = 1. Latch cart_we, cart_addr and cart_wdata; they stay stable until the request ends. The timeout counter is cleared.
  - In CART, the counter increments each cycle.
  - If cart_ack arrives: a read loads cart_rdata into bus_data_out. On the same edge cart_req = 0, stall = 0, FSM = IDLE.
  - If the count reaches CART_TIMEOUT-1 without ack: bus_data_out = 0xFF (reads only), cart_timeout_err = 1, cart_req = 0, stall = 0, FSM = IDLE.
  - cart_ack received in IDLE is ignored.
  - New strobes while in CART are ignored. minx is frozen by stall, so none are expected.
- bus_data_out holds its value between accesses. Writes do not change it.
- bios_load_we writes the BIOS on any edge, independent of the FSM. A simultaneous BIOS read returns the old byte.
- cart_timeout_err clears only on reset.
- Reset during CART drops cart_req and stall immediately, without waiting for ack.

Test Plan:
- RAM write/read: write 0x5A to 0x001234. Read 0x001234 → bus_data_out = 0x5A the cycle after the start edge, stall is never high. Read 0x001235 → contents are independent of the 0x5A write.
- BIOS: load 0xC3 at 0x010, then read 0x000010 → 0xC3. Write 0x00 to 0x000010, read again → still 0xC3.
- Cartridge read with 5-cycle ack latency, address 0x2F0102:
  - cart_addr = 0x0F0102, cart_we = 0.
  - stall is high for exactly 5 cycles.
  - cart_rdata = 0x9E → bus_data_out = 0x9E.
- Cartridge timeout: read 0x004000 with cart_ack tied 0 → cart_req falls after 64 cycles, bus_data_out = 0xFF, cart_timeout_err = 1 and stays 1.
- Strobe and register handling:
  - bus_read held high for 3 cycles to 0x001000 → exactly one access.
  - Read 0x002080 → 0x00 with no stall.
  - Simultaneous read+write to 0x001010 with data 0x11 → RAM holds 0x11.
- Reset mid-cartridge: assert reset 2 cycles into a cart write → cart_req and stall drop asynchronously. After release, FSM is IDLE and cart_timeout_err = 0.

Source files
------------

// File: rtl/minx_mem_ctrl_if.sv
// minx_mem_ctrl_if: groups the minx-side bus and the cartridge port of the
// memory controller.
//   bus_*  : minx address/data/strobes in, read data and stall back out.
//   cart_* : request/ack handshake to the external cartridge.
// The slave modport is the controller's view of these signals.
// The master modport is the view of the CPU and cartridge environment.
interface minx_mem_ctrl_if;
   logic [23:0] bus_address;
   logic [7:0]  bus_data_in;
   logic        bus_read;
   logic        bus_write;
   logic [7:0]  bus_data_out;
   logic        stall;
   logic        cart_req;
   logic        cart_we;
   logic [20:0] cart_addr;
   logic [7:0]  cart_wdata;
   logic        cart_ack;
   logic [7:0]  cart_rdata;

   modport slave (
      input  bus_address, bus_data_in, bus_read, bus_write, cart_ack, cart_rdata,
      output bus_data_out, stall, cart_req, cart_we, cart_addr, cart_wdata
   );

   modport master (
      output bus_address, bus_data_in, bus_read, bus_write, cart_ack, cart_rdata,
      input  bus_data_out, stall, cart_req, cart_we, cart_addr, cart_wdata
   );
endinterface

// File: rtl/minx_mem_ctrl.sv
// minx_mem_ctrl: memory stage behind the minx core. It decodes each bus access
// to one of four targets:
//   - BIOS ROM, 0x000000-0x000FFF
//   - work RAM, 0x001000-0x001FFF
//   - register hole, 0x002000-0x0020FF
//   - cartridge, everything above
// BIOS and RAM accesses take a single cycle.
// Cartridge accesses raise stall until the cartridge sends cart_ack, or until
// CART_TIMEOUT cycles have passed.
// Ports:
//   clk, reset         : clock; asynchronous active-high reset
//   bus (slave)        : minx bus and cartridge handshake
//   bios_load_*        : BIOS image write port; it is independent of the FSM
//   cart_timeout_err   : sticky flag for cartridge timeouts; only reset clears it
module minx_mem_ctrl #(
   parameter int BIOS_DEPTH   = 4096,
   parameter int RAM_DEPTH    = 4096,
   parameter int CART_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   minx_mem_ctrl_if.slave      bus,
   input  logic                bios_load_we,
   input  logic [11:0]         bios_load_addr,
   input  logic [7:0]          bios_load_data,
   output logic                cart_timeout_err
);
   localparam int BAW = $clog2(BIOS_DEPTH);
   localparam int RAW = $clog2(RAM_DEPTH);
   localparam int CW  = $clog2(CART_TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CART_TIMEOUT - 1);

   typedef enum logic {IDLE, CART} state_t;

   state_t        state;
   logic [7:0]    bios_mem [BIOS_DEPTH];
   logic [7:0]    ram_mem  [RAM_DEPTH];
   logic          strb, strb_q, start, is_wr;
   logic          sel_bios, sel_ram, sel_reg, sel_cart;
   logic [CW-1:0] cnt;

   assign strb  = bus.bus_read | bus.bus_write;
   // A new access begins only on the rising edge of the strobe.
   // A strobe that is held high therefore produces one access.
   assign start = strb & ~strb_q & (state == IDLE);
   // The write strobe takes priority over the read strobe when both are high.
   assign is_wr = bus.bus_write;

   assign sel_bios = (bus.bus_address[23:12] == 12'h000);
   assign sel_ram  = (bus.bus_address[23:12] == 12'h001);
   assign sel_reg  = (bus.bus_address[23:8]  == 16'h0020);
   assign sel_cart = ~(sel_bios | sel_ram | sel_reg);

   // The memory arrays have no reset.
   // A BIOS read on the same edge as a load sees the old byte, because both
   // are non-blocking assignments.
   always_ff @(posedge clk) begin
      if (bios_load_we)
         bios_mem[bios_load_addr[BAW-1:0]] <= bios_load_data;
      if (start && is_wr && sel_ram)
         ram_mem[bus.bus_address[RAW-1:0]] <= bus.bus_data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         strb_q           <= 1'b0;
         cnt              <= '0;
         bus.bus_data_out <= 8'h00;
         bus.stall        <= 1'b0;
         bus.cart_req     <= 1'b0;
         bus.cart_we      <= 1'b0;
         bus.cart_addr    <= '0;
         bus.cart_wdata   <= 8'h00;
         cart_timeout_err <= 1'b0;
      end else begin
         strb_q <= strb;
         if (state == IDLE) begin
            if (start) begin
               if (sel_cart) begin
                  // Upper address bits are dropped, so the cartridge space
                  // mirrors above 0x1FFFFF.
                  state          <= CART;
                  bus.stall      <= 1'b1;
                  bus.cart_req   <= 1'b1;
                  bus.cart_we    <= is_wr;
                  bus.cart_addr  <= bus.bus_address[20:0];
                  bus.cart_wdata <= bus.bus_data_in;
                  cnt            <= '0;
               end else if (!is_wr) begin
                  if (sel_bios)
                     bus.bus_data_out <= bios_mem[bus.bus_address[BAW-1:0]];
                  else if (sel_ram)
                     bus.bus_data_out <= ram_mem[bus.bus_address[RAW-1:0]];
                  else
                     bus.bus_data_out <= 8'h00;
               end
            end
         end else begin
            cnt <= cnt + 1'b1;
            // If the ack arrives on the final counted cycle, the ack wins.
            if (bus.cart_ack) begin
               if (!bus.cart_we)
                  bus.bus_data_out <= bus.cart_rdata;
               state        <= IDLE;
               bus.stall    <= 1'b0;
               bus.cart_req <= 1'b0;
            end else if (cnt == CNT_LAST) begin
               if (!bus.cart_we)
                  bus.bus_data_out <= 8'hFF;
               cart_timeout_err <= 1'b1;
               state            <= IDLE;
               bus.stall        <= 1'b0;
               bus.cart_req     <= 1'b0;
            end
         end
      end
   end
endmodule
